// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

    localparam int REG_W = 3;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module hz_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use stalls, taken-branch squash, memory-wait freeze, timeout halt.
// state    | meaning
// RUN      | normal issue; hazards resolved per cycle
// MEM_WAIT | data memory access outstanding, pipeline frozen
// ERROR    | memory timeout, core halted until reset
module pipeline_hazard_ctrl #(
    parameter int REG_W       = pipeline_pkg::REG_W,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] PR1_rs,
    input  logic [REG_W-1:0] PR1_rt,
    input  logic             PR1_uses_rs,
    input  logic             PR1_uses_rt,
    input  logic             PR2_MEM_read,
    input  logic [REG_W-1:0] PR2_rd,
    input  logic             PR2_br_taken,
    input  logic             PR3_mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             PC_write,
    output logic             PR1_write,
    output logic             PR2_write,
    output logic             PR3_write,
    output logic             PR1_flush,
    output logic             PR2_bubble,
    output logic             PR4_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import pipeline_pkg::*;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_freeze;
    logic              load_use;
    logic              stall_ev;
    logic              flush_ev;
    logic              in_error;

    assign mem_freeze = PR3_mem_req && !mem_ready;
    assign load_use   = PR2_MEM_read && (PR2_rd != '0) &&
                        ((PR1_uses_rs && (PR1_rs == PR2_rd)) ||
                         (PR1_uses_rt && (PR1_rt == PR2_rd)));
    assign in_error   = (state == ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_freeze) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ERROR;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, independent of state.
    always_comb begin
        PC_write   = 1'b0;
        PR1_write  = 1'b0;
        PR2_write  = 1'b0;
        PR3_write  = 1'b0;
        PR1_flush  = 1'b0;
        PR2_bubble = 1'b0;
        PR4_bubble = 1'b0;
        halted     = 1'b0;
        stall_ev   = 1'b0;
        flush_ev   = 1'b0;
        if (!rst_n) begin
            halted = 1'b0;
        end else if (in_error) begin
            halted = 1'b1;
        end else if (mem_freeze) begin
            PR4_bubble = 1'b1;
            stall_ev   = 1'b1;
        end else if (PR2_br_taken) begin
            PC_write   = 1'b1;
            PR1_write  = 1'b1;
            PR2_write  = 1'b1;
            PR3_write  = 1'b1;
            PR1_flush  = 1'b1;
            PR2_bubble = 1'b1;
            flush_ev   = 1'b1;
        end else if (load_use) begin
            PR2_write  = 1'b1;
            PR3_write  = 1'b1;
            PR2_bubble = 1'b1;
            stall_ev   = 1'b1;
        end else begin
            PC_write   = 1'b1;
            PR1_write  = 1'b1;
            PR2_write  = 1'b1;
            PR3_write  = 1'b1;
        end
    end

    hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_ev),
        .clr   (cnt_clr && !in_error),
        .cnt   (stall_cnt)
    );

    hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_ev),
        .clr   (cnt_clr && !in_error),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: default instance plus a small one (CNT_W=4, MEM_TIMEOUT=4) on shared inputs.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] PR1_rs, PR1_rt, PR2_rd;
    logic       PR1_uses_rs, PR1_uses_rt, PR2_MEM_read, PR2_br_taken;
    logic       PR3_mem_req, mem_ready, cnt_clr;

    logic        pc_w, pr1_w, pr2_w, pr3_w, pr1_f, pr2_b, pr4_b, hlt;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_w, s_pr1_w, s_pr2_w, s_pr3_w, s_pr1_f, s_pr2_b, s_pr4_b, s_hlt;
    logic [3:0]  s_stall_cnt, s_flush_cnt;
    logic [7:0]  ctl, ctl_s;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] C_RST   = 8'h00;
    localparam logic [7:0] C_RUN   = 8'hF0;
    localparam logic [7:0] C_LU    = 8'h34;
    localparam logic [7:0] C_BR    = 8'hFC;
    localparam logic [7:0] C_FRZ   = 8'h02;
    localparam logic [7:0] C_ERR   = 8'h01;

    always #5 clk = ~clk;

    assign ctl   = {pc_w, pr1_w, pr2_w, pr3_w, pr1_f, pr2_b, pr4_b, hlt};
    assign ctl_s = {s_pc_w, s_pr1_w, s_pr2_w, s_pr3_w, s_pr1_f, s_pr2_b, s_pr4_b, s_hlt};

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .PR1_rs(PR1_rs), .PR1_rt(PR1_rt), .PR1_uses_rs(PR1_uses_rs), .PR1_uses_rt(PR1_uses_rt),
        .PR2_MEM_read(PR2_MEM_read), .PR2_rd(PR2_rd), .PR2_br_taken(PR2_br_taken),
        .PR3_mem_req(PR3_mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .PC_write(pc_w), .PR1_write(pr1_w), .PR2_write(pr2_w), .PR3_write(pr3_w),
        .PR1_flush(pr1_f), .PR2_bubble(pr2_b), .PR4_bubble(pr4_b), .halted(hlt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .PR1_rs(PR1_rs), .PR1_rt(PR1_rt), .PR1_uses_rs(PR1_uses_rs), .PR1_uses_rt(PR1_uses_rt),
        .PR2_MEM_read(PR2_MEM_read), .PR2_rd(PR2_rd), .PR2_br_taken(PR2_br_taken),
        .PR3_mem_req(PR3_mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .PC_write(s_pc_w), .PR1_write(s_pr1_w), .PR2_write(s_pr2_w), .PR3_write(s_pr3_w),
        .PR1_flush(s_pr1_f), .PR2_bubble(s_pr2_b), .PR4_bubble(s_pr4_b), .halted(s_hlt),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        PR1_rs = 3'd0; PR1_rt = 3'd0; PR2_rd = 3'd0;
        PR1_uses_rs = 1'b0; PR1_uses_rt = 1'b0; PR2_MEM_read = 1'b0; PR2_br_taken = 1'b0;
        PR3_mem_req = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hazard_rs3();
        PR2_MEM_read = 1'b1; PR2_rd = 3'd3; PR1_rs = 3'd3; PR1_uses_rs = 1'b1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #3;
        check("reset_ctl", ctl, C_RST);
        check("reset_stall", stall_cnt, 0);
        check("reset_flush", flush_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("run_idle", ctl, C_RUN);

        // load-use via rs
        hazard_rs3(); #1;
        check("lu_rs_ctl", ctl, C_LU);
        tick();
        check("lu_rs_stall", stall_cnt, 1);
        idle(); #1;
        check("lu_cleared", ctl, C_RUN);
        // rd == r0 is never a hazard
        hazard_rs3(); PR2_rd = 3'd0; PR1_rs = 3'd0; #1;
        check("lu_r0_ctl", ctl, C_RUN);
        tick();
        check("lu_r0_stall", stall_cnt, 1);
        // rs matches but is not read
        hazard_rs3(); PR1_uses_rs = 1'b0; #1;
        check("lu_nouse_ctl", ctl, C_RUN);
        // load-use via rt
        idle(); PR2_MEM_read = 1'b1; PR2_rd = 3'd5; PR1_rt = 3'd5; PR1_uses_rt = 1'b1; #1;
        check("lu_rt_ctl", ctl, C_LU);
        tick();
        check("lu_rt_stall", stall_cnt, 2);

        // branch overrides load-use
        idle(); hazard_rs3(); PR2_br_taken = 1'b1; #1;
        check("br_lu_ctl", ctl, C_BR);
        tick();
        check("br_flush", flush_cnt, 1);
        check("br_stall", stall_cnt, 2);

        // memory wait 5 cycles, then ready together with a branch
        idle(); PR3_mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("memw_ctl", ctl, C_FRZ);
            tick();
        end
        check("memw_stall", stall_cnt, 7);
        mem_ready = 1'b1; PR2_br_taken = 1'b1; #1;
        check("memw_ready_br", ctl, C_BR);
        tick();
        check("memw_flush", flush_cnt, 2);
        check("memw_stall2", stall_cnt, 7);
        idle(); #1;
        check("memw_run", ctl, C_RUN);

        // timeout on the small instance
        pulse_reset();
        check("to_reset_stall", s_stall_cnt, 0);
        PR3_mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("to_wait_ctl", ctl_s, C_FRZ);
            tick();
        end
        check("to_err_ctl", ctl_s, C_ERR);
        check("to_err_stall", s_stall_cnt, 5);
        hazard_rs3(); PR2_br_taken = 1'b1; #1;
        check("to_err_hold", ctl_s, C_ERR);
        tick();
        check("to_frz_stall", s_stall_cnt, 5);
        check("to_frz_flush", s_flush_cnt, 0);
        idle();
        pulse_reset();
        check("to_release", ctl_s, C_RUN);

        // saturation and clear on the small instance
        hazard_rs3();
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall", s_stall_cnt, 15);
        cnt_clr = 1'b1;
        tick();
        check("clr_stall", s_stall_cnt, 0);
        cnt_clr = 1'b0;
        tick();
        check("clr_restart", s_stall_cnt, 1);

        // async reset while waiting on memory
        idle(); PR3_mem_req = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0; #1;
        check("async_ctl", ctl, C_RST);
        check("async_ctl_s", ctl_s, C_RST);
        check("async_stall", stall_cnt, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("async_rewait", ctl_s, C_FRZ);
        end
        tick();
        check("async_err", ctl_s, C_ERR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
